cdm_err_monitor: RTL and testbench

Sequential error-metric collector for the carry-disregard approximate multipliers. It sits at the output end of a multiplier under test and consumes a valid/ready stream of operand pairs with their approximate products. For each sample it computes the exact product and the error distance, then accumulates error statistics over a fixed-length sweep. When the sweep finishes it holds the results for readout, so characterisation runs in hardware rather than from dumped text files.

---
 rtl/cdm_err_monitor_if.sv | 13 +
 rtl/cdm_err_monitor.sv | 151 +++++++++++++++
 tb/tb_cdm_err_monitor.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdm_err_monitor_if.sv
// Sample stream from the multiplier under test: operands, approximate product, valid/ready.
interface cdm_err_monitor_if #(
  parameter int WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic [2*WIDTH-1:0]     R;

  modport master (output in_valid, A, B, R, input in_ready);
  modport slave  (input in_valid, A, B, R, output in_ready);
endinterface

// File: rtl/cdm_err_monitor.sv
// Error-metric collector for carry-disregard approximate multipliers.
// Optional err_max/argmax tracking is enabled by defining CDM_ERR_MAX_TRACK_EN.
//
// state    | meaning
// ST_IDLE  | no sweep since reset; waiting for start
// ST_RUN   | accepting samples until NUM_SAMPLES handshakes
// ST_DRAIN | last sample accepted; pipeline still emptying
// ST_DONE  | statistics final and held; start begins a new sweep
module cdm_err_monitor #(
  parameter int WIDTH       = 8,
  parameter int NUM_SAMPLES = 65536,
  parameter int SUM_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  cdm_err_monitor_if.slave     smp,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH:0]     sample_cnt,
  output logic [2*WIDTH:0]     err_cnt,
  output logic [SUM_W-1:0]     err_sum,
  output logic [2*WIDTH-1:0]   err_max,
  output logic [WIDTH-1:0]     max_a,
  output logic [WIDTH-1:0]     max_b
);
  localparam int PW = 2*WIDTH;
  localparam int CW = 2*WIDTH + 1;
  localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;
  localparam logic [CW-1:0]    LAST    = CW'(NUM_SAMPLES - 1);
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    remain;
  logic             accept, start_go;

  logic             v1, v2;
  logic [PW-1:0]    p1, r1, ed2;
  logic signed [PW:0] diff;
  logic [PW-1:0]    ed_c;
  logic [AW-1:0]    sum_ext;
  logic [SUM_W-1:0] sum_sat;

  assign smp.in_ready = (state == ST_RUN);
  assign busy         = (state == ST_RUN) || (state == ST_DRAIN);
  assign done         = (state == ST_DONE);
  assign accept       = smp.in_valid && smp.in_ready;
  assign start_go     = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_RUN;
      ST_RUN:   if (accept && (remain == '0)) state_nxt = ST_DRAIN;
      // once stage 1 is empty, the edge that retires stage 2 also enters DONE
      ST_DRAIN: if (!v1) state_nxt = ST_DONE;
      ST_DONE:  if (start) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // remain counts down the samples still to accept after the current one
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      remain <= '0;
    end else begin
      state <= state_nxt;
      if (start_go)
        remain <= LAST;
      else if (accept && (remain != '0))
        remain <= remain - 1'b1;
    end
  end

  assign diff = $signed({1'b0, p1}) - $signed({1'b0, r1});
  assign ed_c = diff[PW] ? PW'(-diff) : PW'(diff);

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      p1  <= '0;
      r1  <= '0;
      ed2 <= '0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      if (accept) begin
        p1 <= PW'(smp.A) * PW'(smp.B);
        r1 <= smp.R;
      end
      if (v1)
        ed2 <= ed_c;
    end
  end

  assign sum_ext = AW'(err_sum) + AW'(ed2);
  assign sum_sat = (sum_ext > AW'(SUM_MAX)) ? SUM_MAX : SUM_W'(sum_ext);

  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      err_sum    <= '0;
    end else if (v2) begin
      sample_cnt <= sample_cnt + 1'b1;
      if (ed2 != '0)
        err_cnt <= err_cnt + 1'b1;
      err_sum <= sum_sat;
    end
  end

`ifdef CDM_ERR_MAX_TRACK_EN
  logic [WIDTH-1:0] a1, b1, a2, b2;

  // strict compare keeps the earliest sample on ties
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      a1      <= '0;
      b1      <= '0;
      a2      <= '0;
      b2      <= '0;
      err_max <= '0;
      max_a   <= '0;
      max_b   <= '0;
    end else begin
      if (accept) begin
        a1 <= smp.A;
        b1 <= smp.B;
      end
      if (v1) begin
        a2 <= a1;
        b2 <= b1;
      end
      if (v2 && (ed2 > err_max)) begin
        err_max <= ed2;
        max_a   <= a2;
        max_b   <= b2;
      end
    end
  end
`else
  assign err_max = '0;
  assign max_a   = '0;
  assign max_b   = '0;
`endif

endmodule

// File: tb/tb_cdm_err_monitor.sv
// Bench for cdm_err_monitor: directed sweeps plus random sweeps against a behavioural model.
module tb_cdm_err_monitor;
  localparam int WIDTH = 8;

`ifdef CDM_ERR_MAX_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  cdm_err_monitor_if #(.WIDTH(WIDTH)) mif ();
  cdm_err_monitor_if #(.WIDTH(WIDTH)) sif ();

  logic        busy, done, busy2, done2;
  logic [16:0] sample_cnt, err_cnt, sample_cnt2, err_cnt2;
  logic [31:0] err_sum;
  logic [15:0] err_sum2;
  logic [15:0] err_max, err_max2;
  logic [7:0]  max_a, max_b, max_a2, max_b2;

  cdm_err_monitor #(.WIDTH(WIDTH), .NUM_SAMPLES(4), .SUM_W(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .smp(mif),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .err_sum(err_sum), .err_max(err_max), .max_a(max_a), .max_b(max_b)
  );

  cdm_err_monitor #(.WIDTH(WIDTH), .NUM_SAMPLES(2), .SUM_W(16)) u_sat (
    .clk(clk), .rst(rst), .start(start2), .smp(sif),
    .busy(busy2), .done(done2), .sample_cnt(sample_cnt2), .err_cnt(err_cnt2),
    .err_sum(err_sum2), .err_max(err_max2), .max_a(max_a2), .max_b(max_b2)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // reference statistics for the main instance
  int unsigned m_cnt, m_err, m_max, m_ma, m_mb;
  longint      m_sum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_ma = 0; m_mb = 0;
  endtask

  task automatic model_add(input int a, input int b, input int r);
    int p, ed;
    p  = a * b;
    ed = (p > r) ? (p - r) : (r - p);
    m_cnt++;
    if (ed != 0) m_err++;
    m_sum = m_sum + ed;
    if (m_sum > 64'd4294967295) m_sum = 64'd4294967295;
    if (ed > int'(m_max)) begin
      m_max = ed; m_ma = a; m_mb = b;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    mif.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
    int guard;
    guard = 0;
    @(negedge clk);
    mif.in_valid = 1'b1;
    mif.A = a; mif.B = b; mif.R = r;
    while (!mif.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", (guard < 50), 1);
    @(posedge clk);
    model_add(a, b, r);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      mif.in_valid = 1'b0;
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".sample_cnt"}, sample_cnt, m_cnt);
    check({tag, ".err_cnt"},    err_cnt,    m_err);
    check({tag, ".err_sum"},    err_sum,    m_sum);
    check({tag, ".err_max"},    err_max,    TRK ? m_max : 0);
    check({tag, ".max_a"},      max_a,      TRK ? m_ma : 0);
    check({tag, ".max_b"},      max_b,      TRK ? m_mb : 0);
  endtask

  // called right after the edge that accepted the last sample
  task automatic finish_check(input string tag);
    @(negedge clk);
    mif.in_valid = 1'b0;
    check({tag, ".drain_ready"}, mif.in_ready, 0);
    check({tag, ".drain_busy"},  busy, 1);
    check({tag, ".done_n1"},     done, 0);
    @(negedge clk);
    check({tag, ".done_n2"},     done, 0);
    @(negedge clk);
    check({tag, ".done"},        done, 1);
    check({tag, ".busy_fall"},   busy, 0);
    check({tag, ".done_ready"},  mif.in_ready, 0);
    check_stats(tag);
    repeat (3) @(negedge clk);
    check({tag, ".done_held"},   done, 1);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic [15:0] rr;
    int          p;
    mif.in_valid = 1'b0; mif.A = '0; mif.B = '0; mif.R = '0;
    sif.in_valid = 1'b0; sif.A = '0; sif.B = '0; sif.R = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.ready_idle", mif.in_ready, 0);
    check_stats("rst");

    // directed errors
    pulse_start();
    check("start.clear", sample_cnt, 0);
    check("start.ready", mif.in_ready, 1);
    send(3, 5, 14); send(255, 255, 0); send(2, 2, 4); send(1, 1, 3);
    finish_check("dir");
    check("dir.err_cnt_const", err_cnt, 3);
    check("dir.err_sum_const", err_sum, 65028);

    // same samples with gaps; start from DONE clears the previous results
    pulse_start();
    check("restart.clear_sum", err_sum, 0);
    send(3, 5, 14); gap(3); send(255, 255, 0); gap(3); send(2, 2, 4); gap(3); send(1, 1, 3);
    finish_check("gap");
    check("gap.err_sum_const", err_sum, 65028);

    // reset mid-sweep
    pulse_start();
    send(10, 10, 7); send(200, 3, 0);
    @(negedge clk);
    mif.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.ready", mif.in_ready, 0);
    check_stats("midrst");
    // start coinciding with rst
    @(negedge clk);
    start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    check("rst_wins.busy", busy, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      send(ra, rb, 16'(ra) * 16'(rb));
    end
    finish_check("after_rst");
    check("after_rst.cnt", sample_cnt, 4);
    check("after_rst.err", err_cnt, 0);

    // start during RUN is ignored; equal-ED tie keeps the first sample
    pulse_start();
    send(2, 2, 12);
    @(negedge clk);
    mif.in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_start.busy", busy, 1);
    send(4, 3, 4); send(1, 1, 1); send(0, 0, 0);
    finish_check("tie");
    check("tie.max_a_const", max_a, TRK ? 2 : 0);
    check("tie.max_b_const", max_b, TRK ? 2 : 0);

    // random sweeps
    for (int k = 0; k < 8; k++) begin
      pulse_start();
      for (int i = 0; i < 4; i++) begin
        ra = 8'($urandom); rb = 8'($urandom);
        p  = int'(ra) * int'(rb);
        case ($urandom_range(0, 2))
          0:       rr = 16'(p);
          1:       rr = 16'(p) ^ 16'($urandom_range(1, 255));
          default: rr = 16'($urandom);
        endcase
        if (i != 0) gap($urandom_range(0, 2));
        send(ra, rb, rr);
      end
      finish_check($sformatf("rnd%0d", k));
    end

    // saturation on the narrow-accumulator instance
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check("sat.ready", sif.in_ready, 1);
    sif.in_valid = 1'b1; sif.A = 8'd255; sif.B = 8'd255; sif.R = 16'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    sif.in_valid = 1'b0;
    check("sat.ready_drain", sif.in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    check("sat.done", done2, 1);
    check("sat.sample_cnt", sample_cnt2, 2);
    check("sat.err_cnt", err_cnt2, 2);
    check("sat.err_sum", err_sum2, 65535);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
